// File: rtl/led_pattern_ctrl_if.sv
// Board-side signal bundle for the LED pattern sequencer: button/switch inputs
// and the registered LED/status outputs. Names carry the sequencer's direction.
interface led_pattern_ctrl_if;
  logic       i_btn_mode;
  logic       i_btn_pause;
  logic [1:0] i_speed;
  logic [7:0] o_led;
  logic [1:0] o_mode;
  logic       o_paused;
  logic       o_step;

  modport master (
    output i_btn_mode, i_btn_pause, i_speed,
    input  o_led, o_mode, o_paused, o_step
  );

  modport slave (
    input  i_btn_mode, i_btn_pause, i_speed,
    output o_led, o_mode, o_paused, o_step
  );
endinterface

// File: rtl/led_pattern_ctrl.sv
// LED bank sequencer: four step patterns driven by a speed-scaled prescaler tick,
// with synchronised mode/pause buttons and a run/pause FSM.
module led_pattern_ctrl #(
  parameter logic [31:0] TICK_DIV = 32'd64000000
) (
  input  logic              clk,
  input  logic              reset,
  led_pattern_ctrl_if.slave bus
);
  typedef enum logic {S_RUN = 1'b0, S_PAUSE = 1'b1} state_t;

  localparam logic DIR_L = 1'b0;
  localparam logic DIR_R = 1'b1;

  state_t      r_state, w_state_nxt;
  logic [2:0]  r_mode_sync, r_pause_sync;
  logic [31:0] r_pc;
  logic [31:0] w_period_raw, w_period, w_pc_last;
  logic [7:0]  r_led, w_led_step;
  logic [1:0]  r_mode;
  logic        r_dir, w_dir_step, r_step;
  logic        w_ev_mode, w_ev_pause, w_run, w_tick, w_advance;

  function automatic logic [7:0] seed_of(input logic [1:0] md);
    case (md)
      2'd0:    return 8'h00;
      2'd1:    return 8'hFF;
      default: return 8'h01;
    endcase
  endfunction

  // Two flops for metastability, third flop only for edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mode_sync  <= '0;
      r_pause_sync <= '0;
    end else begin
      r_mode_sync  <= {r_mode_sync[1:0], bus.i_btn_mode};
      r_pause_sync <= {r_pause_sync[1:0], bus.i_btn_pause};
    end
  end

  assign w_ev_mode  = r_mode_sync[1] & ~r_mode_sync[2];
  assign w_ev_pause = r_pause_sync[1] & ~r_pause_sync[2];

  assign w_period_raw = TICK_DIV >> bus.i_speed;
  assign w_period     = (w_period_raw == 32'd0) ? 32'd1 : w_period_raw;
  assign w_pc_last    = w_period - 32'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_RUN;
    else       r_state <= w_state_nxt;
  end

  // A pause event in RUN freezes the prescaler in that same cycle
  always_comb begin
    w_state_nxt = r_state;
    w_run       = 1'b0;
    case (r_state)
      S_RUN: begin
        if (w_ev_pause) w_state_nxt = S_PAUSE;
        else            w_run       = 1'b1;
      end
      S_PAUSE: begin
        if (w_ev_pause) w_state_nxt = S_RUN;
      end
      default: w_state_nxt = S_RUN;
    endcase
  end

  assign w_tick    = w_run && (r_pc >= w_pc_last);
  assign w_advance = w_tick && !w_ev_mode;

  always_comb begin
    w_led_step = r_led;
    w_dir_step = r_dir;
    case (r_mode)
      2'd0: w_led_step = r_led + 8'd1;
      2'd1: w_led_step = r_led - 8'd1;
      2'd2: w_led_step = {r_led[6:0], r_led[7]};
      default: begin
        if (r_dir == DIR_L) begin
          if (r_led == 8'h80) begin
            w_dir_step = DIR_R;
            w_led_step = 8'h40;
          end else begin
            w_led_step = {r_led[6:0], 1'b0};
          end
        end else begin
          if (r_led == 8'h01) begin
            w_dir_step = DIR_L;
            w_led_step = 8'h02;
          end else begin
            w_led_step = {1'b0, r_led[7:1]};
          end
        end
      end
    endcase
  end

  // Mode reload wins over a coincident tick
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc   <= '0;
      r_led  <= 8'h00;
      r_mode <= 2'd0;
      r_dir  <= DIR_L;
      r_step <= 1'b0;
    end else begin
      r_step <= w_advance;
      if (w_ev_mode) begin
        r_mode <= r_mode + 2'd1;
        r_led  <= seed_of(r_mode + 2'd1);
        r_pc   <= '0;
        r_dir  <= DIR_L;
      end else if (w_tick) begin
        r_pc  <= '0;
        r_led <= w_led_step;
        r_dir <= w_dir_step;
      end else if (w_run) begin
        r_pc <= r_pc + 32'd1;
      end
    end
  end

  assign bus.o_led    = r_led;
  assign bus.o_mode   = r_mode;
  assign bus.o_paused = (r_state == S_PAUSE);
  assign bus.o_step   = r_step;
endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Bench for led_pattern_ctrl with TICK_DIV=8: vector table, directed corner
// sequences and random button/speed activity against a pattern-level model.
module tb_led_pattern_ctrl;
  logic clk = 1'b0;
  logic reset;

  led_pattern_ctrl_if bus ();

  led_pattern_ctrl #(.TICK_DIV(32'd8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: pattern position and cycle counting in plain integers
  int m_led, m_mode, m_bpos, m_pc;
  bit m_paused, m_step;
  bit hm [3];
  bit hp [3];

  typedef struct {
    bit         bm;
    bit         bp;
    logic [1:0] sp;
    int         n;
    logic [7:0] led;
    logic [1:0] mode;
    bit         paused;
    bit         step;
  } vec_t;

  vec_t tbl [$];

  function automatic int seed_of(int md);
    case (md)
      0:       return 0;
      1:       return 255;
      default: return 1;
    endcase
  endfunction

  function automatic int bounce_led(int pos);
    return (pos <= 7) ? (1 << pos) : (1 << (14 - pos));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_led = 0; m_mode = 0; m_bpos = 0; m_pc = 0;
    m_paused = 0; m_step = 0;
    for (int i = 0; i < 3; i++) begin
      hm[i] = 0;
      hp[i] = 0;
    end
  endtask

  task automatic model_edge();
    bit evm, evp, run, tk;
    int per;
    if (reset) begin
      model_reset();
      return;
    end
    evm = hm[1] && !hm[2];
    evp = hp[1] && !hp[2];
    hm[2] = hm[1]; hm[1] = hm[0]; hm[0] = bus.i_btn_mode;
    hp[2] = hp[1]; hp[1] = hp[0]; hp[0] = bus.i_btn_pause;
    per = 8 >> bus.i_speed;
    if (per < 1) per = 1;
    run = !m_paused && !evp;
    tk  = run && (m_pc >= per - 1);
    m_step = 0;
    if (evm) begin
      m_mode = (m_mode + 1) % 4;
      m_led  = seed_of(m_mode);
      m_bpos = 0;
      m_pc   = 0;
    end else begin
      if (run) m_pc = tk ? 0 : m_pc + 1;
      if (tk) begin
        m_step = 1;
        case (m_mode)
          0: m_led = (m_led + 1) % 256;
          1: m_led = (m_led + 255) % 256;
          2: m_led = ((m_led << 1) | (m_led >> 7)) & 255;
          default: begin
            m_bpos = (m_bpos + 1) % 14;
            m_led  = bounce_led(m_bpos);
          end
        endcase
      end
    end
    if (evp) m_paused = !m_paused;
  endtask

  task automatic model_cmp();
    chk("model_led",    32'(bus.o_led),    32'(m_led));
    chk("model_mode",   32'(bus.o_mode),   32'(m_mode));
    chk("model_paused", 32'(bus.o_paused), 32'(m_paused));
    chk("model_step",   32'(bus.o_step),   32'(m_step));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    model_cmp();
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  task automatic add(input bit bm, input bit bp, input logic [1:0] sp, input int n,
                     input logic [7:0] led, input logic [1:0] mode, input bit paused, input bit step);
    vec_t v;
    v.bm = bm; v.bp = bp; v.sp = sp; v.n = n;
    v.led = led; v.mode = mode; v.paused = paused; v.step = step;
    tbl.push_back(v);
  endtask

  task automatic chk_out(input string name, input logic [7:0] led, input logic [1:0] mode,
                         input bit paused, input bit step);
    chk({name, "_led"},    32'(bus.o_led),    32'(led));
    chk({name, "_mode"},   32'(bus.o_mode),   32'(mode));
    chk({name, "_paused"}, 32'(bus.o_paused), 32'(paused));
    chk({name, "_step"},   32'(bus.o_step),   32'(step));
  endtask

  // Reset asserted between clock edges; outputs must clear without a clock
  task automatic async_reset(input string name);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    chk_out(name, 8'h00, 2'd0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  logic [7:0] exp_b [15];

  initial begin
    reset           = 1'b1;
    bus.i_btn_mode  = 1'b0;
    bus.i_btn_pause = 1'b0;
    bus.i_speed     = 2'd0;
    model_reset();
    #1;
    chk_out("reset", 8'h00, 2'd0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Cadence, mode press with held button, pause and resume from held count
    add(0, 0, 2'd0,   8, 8'h01, 2'd0, 0, 1);
    add(0, 0, 2'd0,   1, 8'h01, 2'd0, 0, 0);
    add(0, 0, 2'd0,   7, 8'h02, 2'd0, 0, 1);
    add(0, 0, 2'd0,  24, 8'h05, 2'd0, 0, 1);
    add(1, 0, 2'd0,   2, 8'h05, 2'd0, 0, 0);
    add(1, 0, 2'd0,   1, 8'hFF, 2'd1, 0, 0);
    add(1, 0, 2'd0,   8, 8'hFE, 2'd1, 0, 1);
    add(0, 0, 2'd0,   8, 8'hFD, 2'd1, 0, 1);
    add(0, 1, 2'd0,   2, 8'hFD, 2'd1, 0, 0);
    add(0, 0, 2'd0,   1, 8'hFD, 2'd1, 1, 0);
    add(0, 0, 2'd0, 100, 8'hFD, 2'd1, 1, 0);
    add(0, 1, 2'd0,   2, 8'hFD, 2'd1, 1, 0);
    add(0, 0, 2'd0,   1, 8'hFD, 2'd1, 0, 0);
    add(0, 0, 2'd0,   5, 8'hFD, 2'd1, 0, 0);
    add(0, 0, 2'd0,   1, 8'hFC, 2'd1, 0, 1);

    for (int i = 0; i < tbl.size(); i++) begin
      bus.i_btn_mode  = tbl[i].bm;
      bus.i_btn_pause = tbl[i].bp;
      bus.i_speed     = tbl[i].sp;
      run(tbl[i].n);
      chk_out($sformatf("vec%0d", i), tbl[i].led, tbl[i].mode, tbl[i].paused, tbl[i].step);
    end

    // Mode event on the tick edge: reload wins, no step, full period follows
    run(5);
    bus.i_btn_mode = 1'b1;
    run(3);
    chk_out("mode_on_tick", 8'h01, 2'd2, 1'b0, 1'b0);
    bus.i_btn_mode = 1'b0;
    run(7);
    chk_out("mode_on_tick_wait", 8'h01, 2'd2, 1'b0, 1'b0);
    run(1);
    chk_out("shift_first", 8'h02, 2'd2, 1'b0, 1'b1);

    // Pause event on the tick edge: tick suppressed, resume ticks next edge
    run(5);
    bus.i_btn_pause = 1'b1;
    run(3);
    chk_out("pause_on_tick", 8'h02, 2'd2, 1'b1, 1'b0);
    bus.i_btn_pause = 1'b0;
    run(10);
    chk_out("pause_hold", 8'h02, 2'd2, 1'b1, 1'b0);
    bus.i_btn_pause = 1'b1;
    run(2);
    bus.i_btn_pause = 1'b0;
    run(1);
    chk_out("resume", 8'h02, 2'd2, 1'b0, 1'b0);
    run(1);
    chk_out("resume_tick", 8'h04, 2'd2, 1'b0, 1'b1);

    // Speed raised mid-count: tick on next edge, then every cycle
    run(6);
    bus.i_speed = 2'd3;
    run(1);
    chk_out("speed_up0", 8'h08, 2'd2, 1'b0, 1'b1);
    run(1);
    chk_out("speed_up1", 8'h10, 2'd2, 1'b0, 1'b1);
    run(1);
    chk_out("speed_up2", 8'h20, 2'd2, 1'b0, 1'b1);

    // Bounce sequence at one step per cycle
    bus.i_btn_mode = 1'b1;
    run(2);
    bus.i_btn_mode = 1'b0;
    run(1);
    chk_out("bounce_seed", 8'h01, 2'd3, 1'b0, 1'b0);
    exp_b = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
              8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
    for (int i = 0; i < 15; i++) begin
      run(1);
      chk_out($sformatf("bounce%0d", i), exp_b[i], 2'd3, 1'b0, 1'b1);
    end

    // Mode wraps 3 -> 0, then UP and DOWN wrap at the 8-bit boundary
    bus.i_btn_mode = 1'b1;
    run(2);
    bus.i_btn_mode = 1'b0;
    run(1);
    chk_out("mode_wrap", 8'h00, 2'd0, 1'b0, 1'b0);
    run(255);
    chk_out("up_ff", 8'hFF, 2'd0, 1'b0, 1'b1);
    run(1);
    chk_out("up_wrap", 8'h00, 2'd0, 1'b0, 1'b1);
    bus.i_btn_mode = 1'b1;
    run(2);
    bus.i_btn_mode = 1'b0;
    run(1);
    chk_out("down_seed", 8'hFF, 2'd1, 1'b0, 1'b0);
    run(255);
    chk_out("down_00", 8'h00, 2'd1, 1'b0, 1'b1);
    run(1);
    chk_out("down_wrap", 8'hFF, 2'd1, 1'b0, 1'b1);

    // Asynchronous reset mid-run, then first tick at edge 8
    bus.i_speed = 2'd0;
    async_reset("async_reset");
    run(7);
    chk_out("post_reset_wait", 8'h00, 2'd0, 1'b0, 1'b0);
    run(1);
    chk_out("post_reset_tick", 8'h01, 2'd0, 1'b0, 1'b1);

    // Random buttons and speed against the model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 19) == 0) bus.i_btn_mode  = ~bus.i_btn_mode;
      if ($urandom_range(0, 24) == 0) bus.i_btn_pause = ~bus.i_btn_pause;
      if ($urandom_range(0, 99) == 0) bus.i_speed     = 2'($urandom_range(0, 3));
      if (c == 1500) async_reset("rand_reset");
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
